// File: rtl/console_pkg.sv
// Shared types and constants for the console text buffer.
package console_pkg;

  // One text cell as stored in the character RAM.
  typedef struct packed {
    logic [7:0] character;
    logic [7:0] attribute;
  } cell_t;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_ROW
  } state_t;

  // Anything from space upwards is stored as a glyph; lower codes are controls.
  function automatic logic is_printable(input logic [7:0] b);
    return b >= ASCII_SPACE;
  endfunction

endpackage

// File: rtl/console_text_buffer_text_ram.sv
// Simple dual-port cell RAM: one synchronous write port, one registered read
// port. A read of the cell being written in the same cycle returns old data.
module text_ram
  import console_pkg::*;
#(
  parameter int DEPTH = 2400,
  parameter int AW    = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  cell_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output cell_t         rdata_o
);

  cell_t mem_q [DEPTH];
  cell_t rdata_q;

  // Write and registered read; nonblocking update gives read-old-data.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/console_text_buffer.sv
// Text-mode character store: host byte stream in (terminal semantics with
// wrap, newline and scroll), cell under the beam out with 2-cycle latency.
//
// Host handshake: a byte is taken on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, and in_valid may be held across busy cycles.
module console_text_buffer
  import console_pkg::*;
#(
  parameter int         COLUMNS           = 80,
  parameter int         ROWS              = 30,
  parameter int         CHAR_WIDTH        = 8,
  parameter int         CHAR_HEIGHT       = 16,
  parameter logic [7:0] DEFAULT_ATTRIBUTE = 8'h0F
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic [7:0] character,
  output logic [7:0] attribute,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_attribute,
  output logic [6:0] cursor_x,
  output logic [4:0] cursor_y
);

  localparam int    DEPTH    = COLUMNS * ROWS;
  localparam int    AW       = $clog2(DEPTH);
  localparam int    CW_SHIFT = $clog2(CHAR_WIDTH);
  localparam int    CH_SHIFT = $clog2(CHAR_HEIGHT);
  localparam cell_t BLANK    = '{character: ASCII_SPACE, attribute: DEFAULT_ATTRIBUTE};

  // Logical row to physical row: top_row marks where logical row 0 lives.
  function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] top);
    logic [5:0] s;
    s = {1'b0, lrow} + {1'b0, top};
    if (s >= 6'(ROWS)) s = s - 6'(ROWS);
    return s[4:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
    return AW'(prow) * AW'(COLUMNS) + AW'(col);
  endfunction

  state_t        state_q, state_d;
  logic [6:0]    cur_x_q, cur_x_d;
  logic [4:0]    cur_y_q, cur_y_d;
  logic [4:0]    top_q, top_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [6:0]    clr_col_q, clr_col_d;
  logic [4:0]    clr_row_q, clr_row_d;
  logic          newline;
  logic          we;
  logic [AW-1:0] waddr;
  cell_t         wdata;

  // Write-side state; reset always restarts the full clear from cell 0.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR_ALL;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      top_q      <= '0;
      clr_addr_q <= '0;
      clr_col_q  <= '0;
      clr_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      top_q      <= top_d;
      clr_addr_q <= clr_addr_d;
      clr_col_q  <= clr_col_d;
      clr_row_q  <= clr_row_d;
    end
  end

  // Next-state: clears own the write port; IDLE interprets one host byte.
  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    top_d      = top_q;
    clr_addr_d = clr_addr_q;
    clr_col_d  = clr_col_q;
    clr_row_d  = clr_row_q;
    newline    = 1'b0;
    we         = 1'b0;
    waddr      = clr_addr_q;
    wdata      = BLANK;
    case (state_q)
      CLEAR_ALL: begin
        we = 1'b1;
        if (clr_addr_q == AW'(DEPTH - 1)) state_d = IDLE;
        else clr_addr_d = clr_addr_q + 1'b1;
      end
      CLEAR_ROW: begin
        we    = 1'b1;
        waddr = cell_addr(clr_row_q, clr_col_q);
        if (clr_col_q == 7'(COLUMNS - 1)) state_d = IDLE;
        else clr_col_d = clr_col_q + 7'd1;
      end
      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_data)) begin
            we    = 1'b1;
            waddr = cell_addr(phys_row(cur_y_q, top_q), cur_x_q);
            wdata = '{character: in_data, attribute: in_attribute};
            if (cur_x_q == 7'(COLUMNS - 1)) begin
              cur_x_d = '0;
              newline = 1'b1;
            end else begin
              cur_x_d = cur_x_q + 7'd1;
            end
          end else begin
            case (in_data)
              ASCII_LF: begin
                cur_x_d = '0;
                newline = 1'b1;
              end
              ASCII_CR: cur_x_d = '0;
              ASCII_BS: if (cur_x_q != '0) cur_x_d = cur_x_q - 7'd1;
              ASCII_FF: begin
                cur_x_d    = '0;
                cur_y_d    = '0;
                top_d      = '0;
                clr_addr_d = '0;
                state_d    = CLEAR_ALL;
              end
              default: ;
            endcase
          end
          // Scrolling recycles the old top physical row as the new bottom row.
          if (newline) begin
            if (cur_y_q != 5'(ROWS - 1)) begin
              cur_y_d = cur_y_q + 5'd1;
            end else begin
              top_d     = (top_q == 5'(ROWS - 1)) ? '0 : top_q + 5'd1;
              clr_row_d = top_q;
              clr_col_d = '0;
              state_d   = CLEAR_ROW;
            end
          end
        end
      end
      default: state_d = CLEAR_ALL;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign cursor_x = cur_x_q;
  assign cursor_y = cur_y_q;

  logic [9:0]    rd_col, rd_row;
  logic          rd_oor;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_addr_q;
  logic          oor1_q, oor2_q;
  cell_t         rdata;

  // Beam position to cell address, or an out-of-range flag beyond the grid.
  always_comb begin
    rd_col  = cx >> CW_SHIFT;
    rd_row  = cy >> CH_SHIFT;
    rd_oor  = (rd_col >= 10'(COLUMNS)) || (rd_row >= 10'(ROWS));
    rd_addr = cell_addr(phys_row(rd_row[4:0], top_q), rd_col[6:0]);
  end

  // Read pipeline; out-of-range flags reset high so outputs read blank in reset.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      oor1_q    <= 1'b1;
      oor2_q    <= 1'b1;
    end else begin
      rd_addr_q <= rd_addr;
      oor1_q    <= rd_oor;
      oor2_q    <= oor1_q;
    end
  end

  text_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk_pixel),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rd_addr_q),
    .rdata_o (rdata)
  );

  assign character = oor2_q ? ASCII_SPACE       : rdata.character;
  assign attribute = oor2_q ? DEFAULT_ATTRIBUTE : rdata.attribute;

endmodule

// File: tb/tb_console_text_buffer.sv
// Bench for console_text_buffer: directed host bytes, cell reads checked by a
// scoreboard, cursor and ready timing checked inline.
module tb_console_text_buffer;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] cx, cy;
  logic [7:0] character, attribute;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data, in_attribute;
  logic [6:0] cursor_x;
  logic [4:0] cursor_y;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        rd_req = 1'b0;
  logic        v1 = 1'b0;
  logic        v2 = 1'b0;

  console_text_buffer dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .cx           (cx),
    .cy           (cy),
    .character    (character),
    .attribute    (attribute),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_attribute (in_attribute),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y)
  );

  // clock / watchdog
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // request tracker: the DUT output is valid two edges after a request
  always @(posedge clk_pixel) begin
    v1 <= rd_req;
    v2 <= v1;
  end

  // monitor: pop and compare whenever a requested cell is on the outputs
  always @(negedge clk_pixel) begin
    if (v2) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check(name_q.pop_front(), {16'h0, character, attribute}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic read_cell(input string nm, input int x, input int y,
                           input logic [7:0] ch, input logic [7:0] at);
    @(negedge clk_pixel);
    cx     = 10'(x);
    cy     = 10'(y);
    rd_req = 1'b1;
    exp_q.push_back({ch, at});
    name_q.push_back(nm);
    @(negedge clk_pixel);
    rd_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int n;
    n = 0;
    @(negedge clk_pixel);
    while (!in_ready && n < 5000) begin
      @(negedge clk_pixel);
      n++;
    end
    if (n >= 5000) check("send_timeout", 32'd0, 32'd1);
    in_valid     = 1'b1;
    in_data      = d;
    in_attribute = a;
    @(negedge clk_pixel);
    in_valid = 1'b0;
  endtask

  // counts consecutive cycles with in_ready low, starting at the current one
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 10000) begin
      cnt++;
      @(negedge clk_pixel);
    end
  endtask

  task automatic check_cursor(input string nm, input int x, input int y);
    check({nm, "_x"}, 32'(cursor_x), 32'(x));
    check({nm, "_y"}, 32'(cursor_y), 32'(y));
  endtask

  int n;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_attribute = 8'h00;
    cx = '0; cy = '0;
    repeat (3) @(negedge clk_pixel);
    check("rst_char", 32'(character), 32'h20);
    check("rst_attr", 32'(attribute), 32'h0F);
    check("rst_ready", 32'(in_ready), 32'd0);
    check_cursor("rst_cursor", 0, 0);
    reset = 1'b0;
    wait_ready(n);
    check("clear_all_cycles", 32'(n), 32'd2400);
    read_cell("blank_0_0", 0, 0, 8'h20, 8'h0F);
    read_cell("blank_632_464", 632, 464, 8'h20, 8'h0F);

    // two printable bytes
    send(8'h41, 8'h1E);
    send(8'h42, 8'h1E);
    check_cursor("ab_cursor", 2, 0);
    read_cell("ab_cell1", 8, 0, 8'h42, 8'h1E);
    read_cell("ab_cell0", 0, 0, 8'h41, 8'h1E);

    // wrap after a full row
    send(8'h0D, 8'h00);
    check_cursor("cr_cursor", 0, 0);
    for (int i = 0; i < 80; i++) send(8'h78, 8'h07);
    check_cursor("wrap_cursor", 0, 1);
    read_cell("wrap_last_col", 632, 0, 8'h78, 8'h07);
    read_cell("wrap_first_col", 0, 0, 8'h78, 8'h07);

    // out-of-range beam positions read blank, not an aliased cell
    for (int i = 0; i < 8; i++) send(8'h52, 8'h2A);
    read_cell("row1_col7", 56, 16, 8'h52, 8'h2A);
    read_cell("oor_col", 700, 0, 8'h20, 8'h0F);
    read_cell("oor_row", 0, 480, 8'h20, 8'h0F);

    // form feed, then controls
    send(8'h0C, 8'h00);
    wait_ready(n);
    check("ff1_cycles", 32'(n), 32'd2400);
    send(8'h08, 8'h00);
    send(8'h0D, 8'h00);
    send(8'h07, 8'h00);
    check_cursor("ctl_col0_cursor", 0, 0);
    send(8'h51, 8'h4C);
    check_cursor("q_cursor", 1, 0);
    send(8'h08, 8'h00);
    check_cursor("bs_cursor", 0, 0);
    read_cell("bs_no_erase", 0, 0, 8'h51, 8'h4C);
    send(8'h0C, 8'h00);
    wait_ready(n);
    check("ff2_cycles", 32'(n), 32'd2400);
    check_cursor("ff2_cursor", 0, 0);
    read_cell("ff2_blank_0_0", 0, 0, 8'h20, 8'h0F);
    read_cell("ff2_blank_row1", 56, 16, 8'h20, 8'h0F);
    read_cell("ff2_blank_last", 632, 464, 8'h20, 8'h0F);

    // scroll
    send(8'h41, 8'h11);
    send(8'h0A, 8'h00);
    send(8'h42, 8'h22);
    send(8'h0A, 8'h00);
    for (int i = 0; i < 27; i++) send(8'h0A, 8'h00);
    check_cursor("bottom_cursor", 0, 29);
    send(8'h5A, 8'h33);
    send(8'h0A, 8'h00);
    wait_ready(n);
    check("clear_row_cycles", 32'(n), 32'd80);
    check_cursor("scroll_cursor", 0, 29);
    read_cell("scroll_z", 0, 448, 8'h5A, 8'h33);
    read_cell("scroll_new_bottom", 0, 464, 8'h20, 8'h0F);
    read_cell("scroll_top_row", 0, 0, 8'h42, 8'h22);

    // reset in the middle of a row clear
    send(8'h0A, 8'h00);
    repeat (10) @(negedge clk_pixel);
    reset = 1'b1;
    #1;
    check("midrst_char", 32'(character), 32'h20);
    check("midrst_attr", 32'(attribute), 32'h0F);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check_cursor("midrst_cursor", 0, 0);
    @(negedge clk_pixel);
    reset = 1'b0;
    wait_ready(n);
    check("midrst_clear_cycles", 32'(n), 32'd2400);
    read_cell("midrst_blank_0_0", 0, 0, 8'h20, 8'h0F);
    read_cell("midrst_blank_448", 0, 448, 8'h20, 8'h0F);

    // report
    repeat (4) @(negedge clk_pixel);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
